// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one sequential 32x32 signed multiplier among NUM_REQ requesters
module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 33,
    parameter int ID_W        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_res,
    output logic                    rsp_ovf,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    output logic                    mul_enable,
    output logic                    mul_reset,
    input  logic [63:0]             mul_res,
    input  logic                    mul_ovf
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = $clog2(MUL_LATENCY + 1);
    state_t state, state_nx;
    logic [ID_W-1:0] rr_ptr, grant;
    logic [CW-1:0] cnt;
    logic any;
    assign any = |req_valid;
    assign mul_reset = reset;
    // descending scan so the requester closest after rr_ptr wins
    always_comb begin
        grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            cnt     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            rsp_id  <= '0;
            rsp_res <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any) begin
                mul_a  <= req_a[32*grant +: 32];
                mul_b  <= req_b[32*grant +: 32];
                rsp_id <= grant;
            end
            cnt <= (state == ISSUE) ? CW'(MUL_LATENCY) : (state == WAIT) ? cnt - CW'(1) : cnt;
            if (state == WAIT && cnt == CW'(1)) begin
                rsp_res <= mul_res;
                rsp_ovf <= mul_ovf;
            end
            if (state == RESP && rsp_ready)
                rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
        end
    end
    always_comb begin
        state_nx = (state == IDLE)  ? (any ? ISSUE : IDLE) :
                   (state == ISSUE) ? WAIT :
                   (state == WAIT)  ? ((cnt == CW'(1)) ? RESP : WAIT) :
                                      (rsp_ready ? IDLE : RESP);
    end
    always_comb begin
        req_ready  = (!reset && state == IDLE && any) ? NUM_REQ'(1) << grant : '0;
        mul_enable = !reset && state == ISSUE;
        rsp_valid  = !reset && state == RESP;
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scoreboard bench with a behavioural multiplier and round-robin reference
module tb_mult_share_arbiter;
    localparam int N  = 4;
    localparam int M  = 33;
    localparam int IW = 2;
    logic clk = 0, reset = 1;
    logic [N-1:0] req_valid = '0;
    logic [32*N-1:0] req_a = '0, req_b = '0;
    logic [N-1:0] req_ready;
    logic rsp_valid, rsp_ready = 0, rsp_ovf, mul_enable, mul_reset, mul_ovf;
    logic [63:0] rsp_res, mul_res;
    logic [IW-1:0] rsp_id;
    logic [31:0] mul_a, mul_b;

    mult_share_arbiter #(.NUM_REQ(N), .MUL_LATENCY(M), .ID_W(IW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_ovf(rsp_ovf), .rsp_id(rsp_id), .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable),
        .mul_reset(mul_reset), .mul_res(mul_res), .mul_ovf(mul_ovf));

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [63:0]   res;
        logic          ovf;
        logic [31:0]   a;
        logic [31:0]   b;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0, cyc = 0, acc_cyc = -1000, last_acc = -1000, acc_cnt = 0;
    int mptr = 0, mode = 0, bp_cnt = 0, w;
    bit chk_int = 0, prev_reset = 1, exp_en, exp_v;
    logic signed [63:0] r;

    function automatic logic ovf_fn(input logic [63:0] p);
        return !((&p[63:31]) || !(|p[63:31]));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // multiplier model: product valid M-1 edges after the enable edge, scrambled before that
    logic [63:0] m_prod = '0;
    int m_cnt = 0;
    always @(posedge clk) begin
        if (mul_reset) begin
            m_prod <= '0;
            m_cnt  <= 0;
        end else if (mul_enable) begin
            m_prod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
            m_cnt  <= M - 1;
        end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end
    assign mul_res = (m_cnt == 0) ? m_prod : m_prod ^ 64'hA5A5_5A5A_0F0F_F0F0;
    assign mul_ovf = (m_cnt == 0) ? ovf_fn(m_prod) : !ovf_fn(m_prod);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (mode == 0) rsp_ready = 1;
        else if (mode == 1) rsp_ready = 1'($urandom_range(0, 1));
        else begin
            bp_cnt = rsp_valid ? bp_cnt + 1 : 0;
            rsp_ready = bp_cnt > 10;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_ready", 64'(req_ready), 0);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
            chk("rst_mul_enable", 64'(mul_enable), 0);
            chk("rst_mul_reset", 64'(mul_reset), 1);
            q.delete();
            mptr = 0;
            acc_cyc = -1000;
        end else begin
            if (prev_reset) begin
                chk("rst_mul_a", 64'(mul_a), 0);
                chk("rst_mul_b", 64'(mul_b), 0);
                chk("rst_rsp_res", rsp_res, 0);
                chk("rst_rsp_id", 64'(rsp_id), 0);
                chk("rst_rsp_ovf", 64'(rsp_ovf), 0);
            end
            chk("mul_reset_low", 64'(mul_reset), 0);
            if (q.size() == 0 && req_valid != 0) begin
                w = -1;
                for (int k = N - 1; k >= 0; k--) if (req_valid[IW'((mptr + k) % N)]) w = (mptr + k) % N;
                chk("grant", 64'(req_ready), 64'(N'(1) << w));
                r = $signed(req_a[32*w +: 32]) * $signed(req_b[32*w +: 32]);
                q.push_back('{id: IW'(w), res: r, ovf: ovf_fn(r), a: req_a[32*w +: 32], b: req_b[32*w +: 32]});
                if (chk_int) chk("issue_interval", 64'(cyc - last_acc), M + 3);
                last_acc = cyc;
                acc_cyc = cyc;
                acc_cnt++;
            end else chk("no_grant", 64'(req_ready), 0);
            exp_en = q.size() > 0 && cyc == acc_cyc + 1;
            if (exp_en || mul_enable) chk("mul_enable", 64'(mul_enable), 64'(exp_en));
            if (exp_en) begin
                chk("mul_a", 64'(mul_a), 64'(q[0].a));
                chk("mul_b", 64'(mul_b), 64'(q[0].b));
            end
            exp_v = q.size() > 0 && cyc >= acc_cyc + M + 2;
            if (exp_v || rsp_valid) chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (exp_v && rsp_valid) begin
                chk("rsp_res", rsp_res, q[0].res);
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("rsp_ovf", 64'(rsp_ovf), 64'(q[0].ovf));
                if (rsp_ready) begin
                    mptr = (int'(q[0].id) + 1) % N;
                    void'(q.pop_front());
                end
            end
        end
        prev_reset = reset;
    end

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = a;
            req_b[32*i +: 32] = b;
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
    endtask

    task automatic wait_acc(input int n, input bit rnd);
        int start = acc_cnt;
        int t = 0;
        while (acc_cnt < start + n && t < 1000) begin
            @(posedge clk);
            #1;
            if (rnd) rand_ops();
            t++;
        end
        if (acc_cnt < start + n) begin
            errors++;
            $display("FAIL accept_timeout at cycle %0d: got %0d accepts expected %0d", cyc, acc_cnt - start, n);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, q.size());
        end
    endtask

    task automatic op(input logic [N-1:0] mask, input logic [31:0] a, input logic [31:0] b);
        req_valid = mask;
        set_ops(a, b);
        wait_acc(1, 0);
        req_valid = '0;
        drain();
    endtask

    task automatic apply_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        op(4'b0001, 32'd7, 32'hFFFF_FFFD);
        apply_reset();
        req_valid = 4'hF;
        rand_ops();
        wait_acc(1, 1);
        chk_int = 1;
        wait_acc(4, 1);
        chk_int = 0;
        req_valid = '0;
        drain();
        op(4'b0100, $urandom, $urandom);
        op(4'b0010, $urandom, $urandom);
        op(4'b1111, $urandom, $urandom);
        mode = 2;
        req_valid = 4'hF;
        wait_acc(2, 1);
        req_valid = '0;
        drain();
        mode = 0;
        op(4'b0001, 32'h8000_0000, 32'h8000_0000);
        op(4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        rand_ops();
        wait_acc(1, 0);
        req_valid = '0;
        repeat (24) @(posedge clk);
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        op(4'b0001, $urandom, $urandom);
        mode = 1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1 req_valid = N'($urandom);
            rand_ops();
        end
        req_valid = '0;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
